// File: rtl/state_seq_pkg.sv
// rtl/state_seq_pkg.sv - shared state/command codes for the state sequencer
package state_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_ARM   = 3'b001;
  localparam logic [2:0] ST_RUN_A = 3'b010;
  localparam logic [2:0] ST_RUN_B = 3'b011;
  localparam logic [2:0] ST_FLUSH = 3'b100;
  localparam logic [2:0] ST_HALT  = 3'b101;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_dwell_cnt.sv
// rtl/seq_dwell_cnt.sv - loadable down-counter that stops at zero
module seq_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - command-driven FSM producing the 3-bit state code
module state_sequencer
  import state_seq_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int ARM_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  input  logic [DWELL_W-1:0] run_len,
  output logic               cmd_ready,
  output logic [2:0]         state,
  output logic               busy,
  output logic               done,
  output logic [7:0]         err_cnt
);

  localparam logic [DWELL_W-1:0] ARM_LD   = DWELL_W'(ARM_CYCLES - 1);
  localparam logic [DWELL_W-1:0] FLUSH_LD = DWELL_W'(FLUSH_CYCLES - 1);

  logic [2:0]         state_q, state_d;
  logic               done_q, done_d;
  logic [7:0]         err_q, err_d;
  logic [DWELL_W-1:0] len_q, len_d;
  logic               dwell_load, dwell_dec, dwell_zero;
  logic [DWELL_W-1:0] dwell_val;
  logic               accept, is_start, is_stop, is_abort;

  assign cmd_ready = (state_q != ST_FLUSH);
  assign accept    = cmd_valid & cmd_ready;
  assign is_start  = accept && (cmd == CMD_START);
  assign is_stop   = accept && (cmd == CMD_STOP);
  assign is_abort  = accept && (cmd == CMD_ABORT);

  seq_dwell_cnt #(.W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dwell_load),
    .load_val_i (dwell_val),
    .dec_i      (dwell_dec),
    .zero_o     (dwell_zero)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    err_d      = err_q;
    len_d      = len_q;
    dwell_load = 1'b0;
    dwell_val  = '0;
    dwell_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (is_start) begin
          len_d = run_len;
          if (run_len == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_ARM;
            dwell_load = 1'b1;
            dwell_val  = ARM_LD;
          end
        end else if (is_stop) begin
          state_d = ST_IDLE;
        end else if (is_abort) begin
          state_d    = ST_FLUSH;
          dwell_load = 1'b1;
          dwell_val  = FLUSH_LD;
        end
      end
      ST_ARM: begin
        if (is_stop) begin
          state_d = ST_IDLE;
        end else if (is_abort) begin
          state_d    = ST_FLUSH;
          dwell_load = 1'b1;
          dwell_val  = FLUSH_LD;
        end else begin
          if (is_start) err_d = sat_inc8(err_q);
          if (dwell_zero) begin
            state_d    = ST_RUN_A;
            dwell_load = 1'b1;
            dwell_val  = len_q - DWELL_W'(1);
          end else begin
            dwell_dec = 1'b1;
          end
        end
      end
      ST_RUN_A, ST_RUN_B: begin
        // STOP/ABORT take priority over expiry; a rejected START only counts an error
        if (is_stop) begin
          state_d = ST_HALT;
        end else if (is_abort) begin
          state_d    = ST_FLUSH;
          dwell_load = 1'b1;
          dwell_val  = FLUSH_LD;
        end else begin
          if (is_start) err_d = sat_inc8(err_q);
          if (dwell_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            dwell_dec = 1'b1;
            state_d   = (state_q == ST_RUN_A) ? ST_RUN_B : ST_RUN_A;
          end
        end
      end
      ST_FLUSH: begin
        if (dwell_zero) state_d = ST_HALT;
        else dwell_dec = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = sat_inc8(err_q);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      err_q   <= 8'd0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign state   = state_q;
  assign done    = done_q;
  assign err_cnt = err_q;
  assign busy    = (state_q == ST_ARM) || (state_q == ST_RUN_A) ||
                   (state_q == ST_RUN_B) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_state_sequencer.sv
// tb/tb_state_sequencer.sv - scoreboard bench for state_sequencer
module tb_state_sequencer;

  localparam logic [2:0] IDLE = 3'b000, ARM = 3'b001, RA = 3'b010,
                         RB = 3'b011, FL = 3'b100, HALT = 3'b101;
  localparam logic [1:0] NOP = 2'b00, START = 2'b01, STOP = 2'b10, ABORT = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = NOP;
  logic [7:0] run_len = 8'd0;
  logic       cmd_ready, busy, done;
  logic [2:0] state;
  logic [7:0] err_cnt;

  typedef struct {
    logic [2:0] st;
    logic       rdy;
    logic       bsy;
    logic       dn;
    logic [7:0] err;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] err_model = 8'd0;

  state_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .run_len   (run_len),
    .cmd_ready (cmd_ready),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Drive inputs on the falling edge and queue what must be seen after the next rising edge.
  task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [7:0] l,
                      input logic [2:0] st, input logic dn, input logic [7:0] e,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; cmd_valid = v; cmd = c; run_len = l;
    x.st   = st;
    x.rdy  = (st != FL);
    x.bsy  = (st == ARM) || (st == RA) || (st == RB) || (st == FL);
    x.dn   = dn;
    x.err  = e;
    x.name = nm;
    exp_q.push_back(x);
  endtask

  task automatic spam_run(input logic [7:0] len, input string nm);
    logic [2:0] st;
    step(0, 1, START, len, ARM, 0, err_model, {nm, "_start"});
    for (int k = 1; k <= len + 4; k++) begin
      err_model = (err_model == 8'hFF) ? err_model : err_model + 8'd1;
      if (k <= 3)           st = ARM;
      else if (k <= len + 3) st = ((k - 4) % 2 == 1) ? RB : RA;
      else                  st = IDLE;
      step(0, 1, START, 8'd7, st, (k == len + 4), err_model, nm);
    end
    step(0, 0, NOP, 0, IDLE, 0, err_model, {nm, "_after"});
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if ({state, cmd_ready, busy, done, err_cnt} != {x.st, x.rdy, x.bsy, x.dn, x.err}) begin
        errors++;
        $display("FAIL %s: got state=%b ready=%b busy=%b done=%b err=%0d, want state=%b ready=%b busy=%b done=%b err=%0d",
                 x.name, state, cmd_ready, busy, done, err_cnt,
                 x.st, x.rdy, x.bsy, x.dn, x.err);
      end
    end
  end

  initial begin
    step(1, 0, NOP, 0, IDLE, 0, 0, "reset0");
    step(1, 0, NOP, 0, IDLE, 0, 0, "reset1");
    step(0, 0, NOP, 0, IDLE, 0, 0, "idle_after_reset");
    step(0, 0, START, 5, IDLE, 0, 0, "start_not_valid");
    step(0, 1, STOP, 0, IDLE, 0, 0, "stop_in_idle");

    step(0, 1, START, 5, ARM, 0, 0, "run5_arm0");
    for (int i = 1; i < 4; i++) step(0, 0, NOP, 0, ARM, 0, 0, "run5_arm");
    step(0, 0, NOP, 0, RA, 0, 0, "run5_a0");
    step(0, 0, NOP, 0, RB, 0, 0, "run5_b0");
    step(0, 0, NOP, 0, RA, 0, 0, "run5_a1");
    step(0, 0, NOP, 0, RB, 0, 0, "run5_b1");
    step(0, 0, NOP, 0, RA, 0, 0, "run5_a2");
    step(0, 0, NOP, 0, IDLE, 1, 0, "run5_done");
    step(0, 0, NOP, 0, IDLE, 0, 0, "run5_done_clear");

    step(0, 1, START, 0, IDLE, 1, 0, "zero_len_done");
    step(0, 0, NOP, 0, IDLE, 0, 0, "zero_len_after");

    step(0, 1, START, 3, ARM, 0, 0, "arm_stop_start");
    step(0, 1, STOP, 0, IDLE, 0, 0, "arm_stop");

    step(0, 1, START, 5, ARM, 0, 0, "halt_arm0");
    for (int i = 1; i < 4; i++) step(0, 1, NOP, 0, ARM, 0, 0, "halt_arm");
    step(0, 0, NOP, 0, RA, 0, 0, "halt_ra");
    step(0, 0, NOP, 0, RB, 0, 0, "halt_rb");
    step(0, 1, STOP, 0, HALT, 0, 0, "stop_in_runb");
    step(0, 0, NOP, 0, HALT, 0, 0, "halt_hold");
    step(0, 1, ABORT, 0, FL, 0, 0, "flush0");
    step(0, 1, START, 5, FL, 0, 0, "flush1_ignores_cmd");
    step(0, 0, NOP, 0, FL, 0, 0, "flush2");
    step(0, 0, NOP, 0, HALT, 0, 0, "flush_to_halt");
    step(0, 1, STOP, 0, IDLE, 0, 0, "halt_stop");
    step(0, 1, ABORT, 0, FL, 0, 0, "idle_abort");
    for (int i = 0; i < 2; i++) step(0, 0, NOP, 0, FL, 0, 0, "idle_abort_fl");
    step(0, 0, NOP, 0, HALT, 0, 0, "idle_abort_halt");
    step(0, 1, START, 0, IDLE, 1, 0, "halt_start_zero");

    err_model = 8'd0;
    spam_run(8'd255, "spam255");
    spam_run(8'd38, "spam38");

    step(0, 1, START, 2, ARM, 0, err_model, "abort_exp_arm0");
    for (int i = 1; i < 4; i++) step(0, 0, NOP, 0, ARM, 0, err_model, "abort_exp_arm");
    step(0, 0, NOP, 0, RA, 0, err_model, "abort_exp_ra");
    step(0, 0, NOP, 0, RB, 0, err_model, "abort_exp_rb");
    step(0, 1, ABORT, 0, FL, 0, err_model, "abort_beats_expiry");
    step(0, 0, NOP, 0, FL, 0, err_model, "abort_fl1");
    step(1, 0, NOP, 0, IDLE, 0, 0, "reset_mid_flush");
    step(0, 0, NOP, 0, IDLE, 0, 0, "idle_after_reset2");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
